// File: rtl/cmd_pack.sv
// Layer descriptor to 7-word packed command encoder feeding the command FIFO.
// Define CMD_PACK_CHECK_EN to reject descriptors with illegal fields.
module cmd_pack #(
   parameter int PARA     = 16,
   parameter int MAX_CMDS = 18
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        desc_valid,
   output logic        desc_ready,
   input  logic [2:0]  op_type,
   input  logic        padding,
   input  logic [3:0]  stride,
   input  logic [15:0] op_num_center,
   input  logic [15:0] op_num_corner,
   input  logic [15:0] op_num_side,
   input  logic [15:0] i_channel_size,
   input  logic [15:0] o_channel_size,
   input  logic [7:0]  i_side_size,
   input  logic [7:0]  o_side_size,
   input  logic [15:0] o_surf_size,
   input  logic [31:0] weight_start_addr,
   input  logic [31:0] data_start_addr,
   input  logic [31:0] result_addr,
   input  logic        cmd_fifo_full,
   output logic        cmd_fifo_wr_en,
   output logic [31:0] cmd_fifo_din,
   output logic [6:0]  cmd_size,
   output logic        busy,
   output logic        err_illegal,
   output logic        err_overflow
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t      state, next_state;
   logic [2:0]  word_idx;
   logic [31:0] w0, w1, w2, w3, w4, w5, w6;

   logic accept, ovf_hit, illegal, go, last;

   assign accept  = (state == IDLE) && desc_valid && !clear;
   assign ovf_hit = (cmd_size == 7'(MAX_CMDS));

`ifdef CMD_PACK_CHECK_EN
   always_comb begin
      illegal = 1'b0;
      if (op_type == 3'd0 || op_type > 3'd5)
         illegal = 1'b1;
      if (o_channel_size == 16'd0)
         illegal = 1'b1;
      if ((o_channel_size % 16'(PARA)) != 16'd0)
         illegal = 1'b1;
      if (o_surf_size == 16'd0)
         illegal = 1'b1;
   end
`else
   assign illegal = 1'b0;
`endif

   assign go   = accept && !ovf_hit && !illegal;
   assign last = cmd_fifo_wr_en && (word_idx == 3'd6);

   always_comb begin
      next_state     = state;
      desc_ready     = 1'b0;
      busy           = 1'b0;
      cmd_fifo_wr_en = 1'b0;
      cmd_fifo_din   = 32'd0;
      unique case (state)
         IDLE: begin
            desc_ready = !clear;
            if (go)
               next_state = EMIT;
         end
         EMIT: begin
            busy           = 1'b1;
            cmd_fifo_wr_en = !cmd_fifo_full && !clear;
            case (word_idx)
               3'd0:    cmd_fifo_din = w0;
               3'd1:    cmd_fifo_din = w1;
               3'd2:    cmd_fifo_din = w2;
               3'd3:    cmd_fifo_din = w3;
               3'd4:    cmd_fifo_din = w4;
               3'd5:    cmd_fifo_din = w5;
               3'd6:    cmd_fifo_din = w6;
               default: cmd_fifo_din = 32'd0;
            endcase
            if (last)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         word_idx     <= 3'd0;
         cmd_size     <= 7'd0;
         err_illegal  <= 1'b0;
         err_overflow <= 1'b0;
      end else if (clear) begin
         state        <= IDLE;
         word_idx     <= 3'd0;
         cmd_size     <= 7'd0;
         err_illegal  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         state <= next_state;
         if (accept && ovf_hit)
            err_overflow <= 1'b1;
         else if (accept && illegal)
            err_illegal <= 1'b1;
         if (go)
            word_idx <= 3'd0;
         else if (last) begin
            word_idx <= 3'd0;
            cmd_size <= cmd_size + 7'd1;
         end else if (cmd_fifo_wr_en)
            word_idx <= word_idx + 3'd1;
      end
   end

   // Shadow copy already in packed word form; inputs may change after accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w0 <= 32'd0;
         w1 <= 32'd0;
         w2 <= 32'd0;
         w3 <= 32'd0;
         w4 <= 32'd0;
         w5 <= 32'd0;
         w6 <= 32'd0;
      end else if (accept) begin
         w0 <= {op_num_center, 4'b0, stride, 3'b0, padding, 1'b0, op_type};
         w1 <= {op_num_side, op_num_corner};
         w2 <= {o_channel_size, i_channel_size};
         w3 <= {o_surf_size, o_side_size, i_side_size};
         w4 <= weight_start_addr;
         w5 <= data_start_addr;
         w6 <= result_addr;
      end
   end

endmodule

// File: doc/cmd_pack.md
Name: cmd_pack

Overview:
- Command encoder; the write-side counterpart of the command sequencer.
- Accepts one layer descriptor per handshake and serializes it into the 7-word, 32-bit packed command format.
- Writes the words into the command FIFO that feeds the SDRAM command region, and tracks the command count the sequencer consumes as cmd_size.
- Sits between the host register bank and the command FIFO write port.

Parameters:
- PARA, 16, engine parallelism; o_channel_size must be a nonzero multiple of this.
- MAX_CMDS, 18, maximum commands held in the 128-word command region (floor(128/7)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- clear  in  1  sync clear: abort, cmd_size and error flags to 0
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accept
- op_type  in  3  1/2/3 conv, 4 maxpool, 5 avepool
- padding  in  1
- stride  in  4
- op_num_center / op_num_corner / op_num_side  in  16 each
- i_channel_size / o_channel_size  in  16 each
- i_side_size / o_side_size  in  8 each
- o_surf_size  in  16
- weight_start_addr / data_start_addr / result_addr  in  32 each
- cmd_fifo_full  in  1  FIFO full
- cmd_fifo_wr_en  out  1  FIFO write strobe
- cmd_fifo_din  out  32  FIFO write data
- cmd_size  out  7  commands fully written since reset/clear
- busy  out  1  emission in progress
- err_illegal  out  1  sticky: descriptor rejected by field check
- err_overflow  out  1  sticky: descriptor rejected, region full

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). All registers clear to 0, state IDLE.
- Reset values of outputs: desc_ready=1, cmd_fifo_wr_en=0, cmd_fifo_din=0, cmd_size=0, busy=0, errors=0.
- Word layout, emitted in order W0..W6:
  - W0 = {op_num_center, 4'b0, stride, 3'b0, padding, 1'b0, op_type}
  - W1 = {op_num_side, op_num_corner}
  - W2 = {o_channel_size, i_channel_size}
  - W3 = {o_surf_size, o_side_size, i_side_size}
  - W4 = weight_start_addr
  - W5 = data_start_addr
  - W6 = result_addr
- States: IDLE, EMIT.
- IDLE:
  - desc_ready=1.
  - On desc_valid, all fields are captured into shadow registers and checked:
    - cmd_size==MAX_CMDS -> set err_overflow, drop, stay IDLE.
    - Else an illegal descriptor sets err_illegal, drops, stays IDLE. Illegal means op_type 0/6/7, o_channel_size==0, o_channel_size%PARA!=0, or o_surf_size==0.
    - Else go to EMIT with word_idx=0.
- EMIT:
  - desc_ready=0, busy=1.
  - cmd_fifo_wr_en = !cmd_fifo_full && !clear, combinational, so no write occurs into a full FIFO.
  - cmd_fifo_din = W[word_idx], combinational mux of the shadow registers.
  - word_idx increments on each write.
  - On the write of W6: cmd_size increments and the next state is IDLE.
- Latency and throughput:
  - First word is on the FIFO port the cycle after acceptance.
  - 8 cycles per command when the FIFO is never full.
  - A full FIFO stalls word_idx indefinitely with no loss or duplication.
- Input stability: input fields may change after acceptance; only shadow copies are emitted.
- clear: has priority over all other activity in any state; next state is IDLE, cmd_size=0, errors=0. A partial command may remain in the FIFO; the FIFO owner flushes it.
- rst_n mid-EMIT: same as clear, asynchronously.
- Error flags: sticky until clear or reset; they do not block later valid descriptors.
- cmd_size width: never exceeds MAX_CMDS, so it does not wrap in 7 bits.

Optional Feature:
- Macro CMD_PACK_CHECK_EN.
- Defined: the field check above is active.
- Undefined: all descriptors are packed unchecked except for the overflow check; err_illegal is tied to 0.

Test Plan:
- Conv3x3 descriptor with op_type=2, padding=0, stride=1, center=0x0090, corner=0x0040, side=0x0060, ich=64, och=128, iside=55, oside=53, osurf=2809, weight=0x00001000, data=0x000A0000, result=0x000C0000, FIFO never full -> W0..W6 = 0x00900102, 0x00600040, 0x00800040, 0x0AF93537, 0x00001000, 0x000A0000, 0x000C0000 on 7 consecutive cycles; cmd_size=1; desc_ready high again 8 cycles after acceptance.
- Same descriptor with cmd_fifo_full held high for 5 cycles starting after W2 -> exactly 7 writes, no duplicate W3, wr_en=0 throughout the full cycles.
- op_type=0, then o_channel_size=24 -> each descriptor dropped with no FIFO write and err_illegal=1. With CMD_PACK_CHECK_EN undefined, both are packed and err_illegal=0.
- Pack 18 valid commands, then a 19th -> cmd_size=18, err_overflow=1, no writes for the 19th; clear -> cmd_size=0, flags cleared.
- Assert clear after W3, then rst_n low after W5 on a second command -> wr_en drops the same cycle in both cases; cmd_size=0; state IDLE; desc_ready=1.
